// File: rtl/branch_predict_unit_pkg.sv
// Shared types and helpers for the branch predictor: BTB entry layout,
// counter initial values and PC index/tag extraction.
package bpu_types_pkg;

    localparam int CTR_MAX_W = 4;
    localparam int TAG_MAX_W = 30;

    // MSB-aligned patterns; a CTR_W-bit counter takes the top CTR_W bits.
    localparam logic [CTR_MAX_W-1:0] CTR_WEAK_T  = 4'b1000;
    localparam logic [CTR_MAX_W-1:0] CTR_WEAK_NT = 4'b0111;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
    } btb_entry_t;

    function automatic logic [7:0] idx_of(input logic [31:0] pc, input int idx_w);
        logic [31:0] m;
        m = (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
        return m[7:0];
    endfunction

    function automatic logic [TAG_MAX_W-1:0] tag_of(input logic [31:0] pc, input int idx_w);
        logic [31:0] t;
        t = pc >> (idx_w + 2);
        return t[TAG_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Predictor bus: IF-stage lookup, MM-stage resolution/training, flush and statistics.
interface branch_predict_unit_if #(
    parameter int HIST_W = 4
);
    logic [31:0]       lk_pc;
    logic              pred_taken;
    logic [31:0]       pred_target;
    logic [HIST_W-1:0] pred_hist;
    logic              upd_en;
    logic [31:0]       upd_pc;
    logic              upd_taken;
    logic [31:0]       upd_target;
    logic              upd_mispred;
    logic [HIST_W-1:0] upd_hist;
    logic              flush_all;
    logic [31:0]       stat_lookups;
    logic [31:0]       stat_mispreds;

    modport slave (
        input  lk_pc, upd_en, upd_pc, upd_taken, upd_target, upd_mispred, upd_hist, flush_all,
        output pred_taken, pred_target, pred_hist, stat_lookups, stat_mispreds
    );

    modport master (
        output lk_pc, upd_en, upd_pc, upd_taken, upd_target, upd_mispred, upd_hist, flush_all,
        input  pred_taken, pred_target, pred_hist, stat_lookups, stat_mispreds
    );
endinterface

// File: rtl/branch_predict_unit_sat_counter.sv
// Saturating up/down counter with load; one per BTB entry.
module sat_counter #(
    parameter int               CTR_W = 2,
    parameter logic [CTR_W-1:0] INIT  = '0
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             load_i,
    input  logic [CTR_W-1:0] load_val_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CTR_W-1:0] cnt_o
);
    logic [CTR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (inc_i && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
        else if (dec_i && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) cnt_q <= INIT;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB branch predictor with saturating counters and statistics.
// Optional gshare indexing is enabled by defining BPU_GHIST_EN.
module branch_predict_unit
    import bpu_types_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int HIST_W  = 4
) (
    input logic                   CLK,
    input logic                   nRST,
    branch_predict_unit_if.slave  bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] CTR_INIT_T  = CTR_WEAK_T[CTR_MAX_W-1 -: CTR_W];
    localparam logic [CTR_W-1:0] CTR_INIT_NT = CTR_WEAK_NT[CTR_MAX_W-1 -: CTR_W];

    typedef logic [IDX_W-1:0] idx_t;

    btb_entry_t           btb [ENTRIES];
    logic [CTR_W-1:0]     ctr [ENTRIES];
    idx_t                 lk_idx, up_idx;
    logic [TAG_MAX_W-1:0] lk_tag, up_tag;
    logic                 lk_hit, up_hit;
    logic [31:0]          stat_lookups_q, stat_mispreds_q;

`ifdef BPU_GHIST_EN
    logic [HIST_W-1:0] ghr_q, ghr_d;

    assign lk_idx        = idx_t'(idx_of(bus.lk_pc, IDX_W)) ^ idx_t'(ghr_q);
    assign up_idx        = idx_t'(idx_of(bus.upd_pc, IDX_W)) ^ idx_t'(bus.upd_hist);
    assign bus.pred_hist = ghr_q;
    // Rebuild history from the fetched snapshot so mispredicted speculation is repaired.
    assign ghr_d         = HIST_W'({bus.upd_hist, bus.upd_taken});

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)           ghr_q <= '0;
        else if (bus.upd_en) ghr_q <= ghr_d;
    end
`else
    logic unused_hist;

    assign lk_idx        = idx_t'(idx_of(bus.lk_pc, IDX_W));
    assign up_idx        = idx_t'(idx_of(bus.upd_pc, IDX_W));
    assign bus.pred_hist = '0;
    assign unused_hist   = ^bus.upd_hist;
`endif

    assign lk_tag = tag_of(bus.lk_pc, IDX_W);
    assign up_tag = tag_of(bus.upd_pc, IDX_W);
    assign lk_hit = btb[lk_idx].valid && (btb[lk_idx].tag == lk_tag);
    assign up_hit = btb[up_idx].valid && (btb[up_idx].tag == up_tag);

    // Lookup sees registered contents only, so a same-cycle update shows next cycle.
    assign bus.pred_taken  = lk_hit && ctr[lk_idx][CTR_W-1];
    assign bus.pred_target = lk_hit ? btb[lk_idx].target : 32'd0;

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
        btb_entry_t entry_q, entry_d;
        logic       sel, inc, dec, alloc;

        assign sel   = bus.upd_en && (up_idx == idx_t'(gi));
        assign inc   = sel && up_hit && bus.upd_taken;
        assign dec   = sel && up_hit && !bus.upd_taken;
        assign alloc = sel && !up_hit && bus.upd_taken && !bus.flush_all;

        always_comb begin
            entry_d = entry_q;
            if (alloc)
                entry_d = '{valid: 1'b1, tag: up_tag, target: bus.upd_target};
            else if (inc)
                entry_d.target = bus.upd_target;
            if (bus.flush_all)
                entry_d.valid = 1'b0;
        end

        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) entry_q <= '0;
            else       entry_q <= entry_d;
        end

        sat_counter #(.CTR_W(CTR_W), .INIT(CTR_INIT_NT)) u_ctr (
            .CLK        (CLK),
            .nRST       (nRST),
            .load_i     (alloc),
            .load_val_i (CTR_INIT_T),
            .inc_i      (inc),
            .dec_i      (dec),
            .cnt_o      (ctr[gi])
        );

        assign btb[gi] = entry_q;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_lookups_q  <= '0;
            stat_mispreds_q <= '0;
        end else if (bus.upd_en) begin
            stat_lookups_q <= stat_lookups_q + 32'd1;
            if (bus.upd_mispred)
                stat_mispreds_q <= stat_mispreds_q + 32'd1;
        end
    end

    assign bus.stat_lookups  = stat_lookups_q;
    assign bus.stat_mispreds = stat_mispreds_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit (16 entries, 2-bit counters).
module tb_branch_predict_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   exp_lookups = 0;
    int   exp_mispreds = 0;

    always #5 clk = ~clk;

    branch_predict_unit_if #(.HIST_W(4)) bus ();

    branch_predict_unit #(.ENTRIES(16), .CTR_W(2), .HIST_W(4)) dut (
        .CLK  (clk),
        .nRST (rst_n),
        .bus  (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                             input logic mp, input logic [3:0] hist);
        bus.upd_en      = 1'b1;
        bus.upd_pc      = pc;
        bus.upd_taken   = tk;
        bus.upd_target  = tgt;
        bus.upd_mispred = mp;
        bus.upd_hist    = hist;
        exp_lookups++;
        if (mp) exp_mispreds++;
    endtask

    task automatic clear_upd();
        bus.upd_en      = 1'b0;
        bus.upd_mispred = 1'b0;
        bus.flush_all   = 1'b0;
    endtask

    task automatic do_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic mp);
        apply_upd(pc, tk, tgt, mp, 4'd0);
        tick();
        clear_upd();
        #1;
    endtask

    task automatic look(input string name, input logic [31:0] pc, input logic exp_tk, input logic [31:0] exp_tgt);
        bus.lk_pc = pc;
        #1;
        checks++;
        if (bus.pred_taken !== exp_tk) begin
            failures++;
            $display("FAIL %s pred_taken pc=%h got=%0b exp=%0b", name, pc, bus.pred_taken, exp_tk);
        end
        checks++;
        if (bus.pred_target !== exp_tgt) begin
            failures++;
            $display("FAIL %s pred_target pc=%h got=%h exp=%h", name, pc, bus.pred_target, exp_tgt);
        end
        $display("lookup %s pc=%h taken=%0b target=%h", name, pc, bus.pred_taken, bus.pred_target);
    endtask

    task automatic check_stats(input string name);
        checks++;
        if (bus.stat_lookups !== 32'(exp_lookups)) begin
            failures++;
            $display("FAIL %s stat_lookups got=%0d exp=%0d", name, bus.stat_lookups, exp_lookups);
        end
        checks++;
        if (bus.stat_mispreds !== 32'(exp_mispreds)) begin
            failures++;
            $display("FAIL %s stat_mispreds got=%0d exp=%0d", name, bus.stat_mispreds, exp_mispreds);
        end
        $display("stats %s lookups=%0d mispreds=%0d", name, bus.stat_lookups, bus.stat_mispreds);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        exp_lookups = 0;
        exp_mispreds = 0;
        clear_upd();
        bus.upd_pc = '0; bus.upd_taken = 1'b0; bus.upd_target = '0; bus.upd_hist = '0;
        tick();
        look("reset", 32'h40, 1'b0, 32'h0);
        checks++;
        if (bus.pred_hist !== 4'd0) begin
            failures++;
            $display("FAIL reset pred_hist got=%h exp=0", bus.pred_hist);
        end
        check_stats("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_train();
        do_upd(32'h40, 1'b1, 32'h80, 1'b0);       // alloc, ctr=10
        look("train_alloc", 32'h40, 1'b1, 32'h80);
        do_upd(32'h40, 1'b1, 32'h84, 1'b0);       // ctr=11, target updated
        look("train_sat", 32'h40, 1'b1, 32'h84);
        do_upd(32'h40, 1'b0, 32'h99, 1'b0);       // ctr=10, target kept
        look("train_nt1", 32'h40, 1'b1, 32'h84);
        do_upd(32'h40, 1'b0, 32'h99, 1'b1);       // ctr=01
        look("train_nt2", 32'h40, 1'b0, 32'h84);
        do_upd(32'h40, 1'b0, 32'h99, 1'b0);       // ctr=00
        do_upd(32'h40, 1'b0, 32'h99, 1'b0);       // saturates at 00
        do_upd(32'h40, 1'b1, 32'h88, 1'b1);       // 01: still not taken
        look("train_floor", 32'h40, 1'b0, 32'h88);
    endtask

    task automatic test_alias();
        do_upd(32'h80, 1'b1, 32'h100, 1'b0);      // same index as 0x40, new tag
        look("alias_old", 32'h40, 1'b0, 32'h0);
        look("alias_new", 32'h80, 1'b1, 32'h100);
    endtask

    task automatic test_back_to_back();
        bus.lk_pc = 32'h40;
        apply_upd(32'h40, 1'b1, 32'h200, 1'b0, 4'd0);
        #1;
        checks++;
        if (bus.pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL same_cycle pred_taken got=%0b exp=0", bus.pred_taken);
        end
        tick();
        apply_upd(32'h44, 1'b1, 32'h300, 1'b0, 4'd0);   // back-to-back allocation
        #1;
        look("same_cycle_next", 32'h40, 1'b1, 32'h200);
        tick();
        clear_upd();
        look("b2b_second", 32'h44, 1'b1, 32'h300);
        do_upd(32'h48, 1'b0, 32'h400, 1'b0);      // miss not-taken: no allocation
        look("nt_miss", 32'h48, 1'b0, 32'h0);
    endtask

    task automatic test_stats_flush();
        do_upd(32'h50, 1'b1, 32'h500, 1'b0);
        do_upd(32'h54, 1'b1, 32'h540, 1'b1);
        do_upd(32'h50, 1'b0, 32'h0,   1'b0);
        do_upd(32'h58, 1'b0, 32'h0,   1'b1);
        do_upd(32'h54, 1'b1, 32'h544, 1'b0);
        bus.upd_mispred = 1'b1;                   // ignored without upd_en
        tick();
        bus.upd_mispred = 1'b0;
        check_stats("five_updates");
        look("pre_flush", 32'h54, 1'b1, 32'h544);
        bus.flush_all = 1'b1;
        apply_upd(32'h5C, 1'b1, 32'h5C0, 1'b0, 4'd0);   // allocation loses to flush
        tick();
        clear_upd();
        look("flush_40", 32'h40, 1'b0, 32'h0);
        look("flush_44", 32'h44, 1'b0, 32'h0);
        look("flush_54", 32'h54, 1'b0, 32'h0);
        look("flush_alloc", 32'h5C, 1'b0, 32'h0);
        check_stats("after_flush");
    endtask

    task automatic test_reset_mid_update();
        do_upd(32'h60, 1'b1, 32'h600, 1'b0);
        look("pre_reset", 32'h60, 1'b1, 32'h600);
        @(negedge clk);
        apply_upd(32'h64, 1'b1, 32'h640, 1'b0, 4'd0);
        rst_n = 1'b0;
        exp_lookups = 0;
        exp_mispreds = 0;
        #1;
        look("in_reset", 32'h60, 1'b0, 32'h0);
        check_stats("in_reset");
        tick();
        clear_upd();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        look("reset_discard", 32'h64, 1'b0, 32'h0);
    endtask

`ifdef BPU_GHIST_EN
    task automatic test_ghist();
        logic [3:0] ghr;
        logic [3:0] outcomes;
        ghr = 4'd0;
        outcomes = 4'b1101;                        // applied MSB first: 1,1,0,1
        for (int i = 3; i >= 0; i--) begin
            apply_upd(32'h100 + 32'(i) * 32'h1000, outcomes[i], 32'h0, 1'b0, ghr);
            tick();
            clear_upd();
            ghr = {ghr[2:0], outcomes[i]};
        end
        #1;
        checks++;
        if (bus.pred_hist !== 4'b1101) begin
            failures++;
            $display("FAIL ghist_shift pred_hist got=%b exp=1101", bus.pred_hist);
        end
        $display("ghist pred_hist=%b", bus.pred_hist);
        apply_upd(32'h40, 1'b1, 32'h700, 1'b0, 4'b1101);   // entry 0^13 = 13
        tick();
        clear_upd();
        look("ghist_other_hist", 32'h40, 1'b0, 32'h0);      // GHR=1011 -> entry 11
        apply_upd(32'h7C, 1'b1, 32'h7C0, 1'b0, 4'b0110);   // GHR -> 1101
        tick();
        clear_upd();
        look("ghist_same_hist", 32'h40, 1'b1, 32'h700);
    endtask
`endif

    initial begin
        bus.lk_pc = 32'h0;
        test_reset();
`ifdef BPU_GHIST_EN
        test_ghist();
`else
        test_train();
        test_alias();
        test_back_to_back();
        test_stats_flush();
        test_reset_mid_update();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised dynamic branch predictor for the 5-stage MIPS pipeline; supplies the IF-stage predicted-taken flag and predicted target that drive PRBPC selection in hazard control.
- Direct-mapped branch target buffer (BTB) with per-entry saturating counters.
- Trained from the MM stage when a BEQ/BNE resolves; keeps hit/mispredict statistics.
- Sits beside the PC unit; hazard control consumes pred_taken/pred_target and reports resolution through the upd_* port.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, 2..256; IDX_W = log2(ENTRIES).
- CTR_W, 2, saturating counter width, 1..4.
- HIST_W, 4, global history length used only when BPU_GHIST_EN is defined; must be <= IDX_W.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- lk_pc  in  32  IF-stage PC to predict.
- pred_taken  out  1  predict taken (combinational from lk_pc and state).
- pred_target  out  32  predicted branch target.
- pred_hist  out  HIST_W  history snapshot; travels down the pipe with the branch.
- upd_en  in  1  MM-stage branch resolved this cycle (already qualified by pipeline enable).
- upd_pc  in  32  PC of the resolved branch.
- upd_taken  in  1  actual outcome (ABtaken).
- upd_target  in  32  computed branch target.
- upd_mispred  in  1  hazard unit flagged a mispredict (ABtaken xor MMtaken).
- upd_hist  in  HIST_W  pred_hist captured when this branch was fetched.
- flush_all  in  1  synchronous invalidate of every BTB entry.
- stat_lookups  out  32  count of upd_en events.
- stat_mispreds  out  32  count of upd_en with upd_mispred.

Behaviour:
- Entry fields: valid, tag = pc[31:IDX_W+2], target[31:0], ctr[CTR_W-1:0].
- Index: idx(pc) = pc[IDX_W+1:2], optionally hashed (see Optional Feature).
- Lookup, combinational, zero latency:
  - hit = valid && tag match.
  - pred_taken = hit && ctr[MSB].
  - pred_target = entry target when hit, else 0.
- Update on a CLK edge with upd_en = 1:
  - Hit, upd_taken = 1: ctr increments, saturating at all-ones; target <= upd_target.
  - Hit, upd_taken = 0: ctr decrements, saturating at 0; target unchanged.
  - Miss, upd_taken = 1: allocate the entry (overwrites any prior occupant). valid = 1, new tag, target <= upd_target, ctr <= weakly-taken (MSB = 1, other bits 0).
  - Miss, upd_taken = 0: no allocation; table unchanged.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents. The write is visible from the next cycle.
- flush_all clears every valid bit on the next edge. Counters and targets are retained but unused. flush_all wins over a same-cycle upd_en allocation; counters still move on a same-cycle update.
- Statistics counters:
  - stat_lookups increments on each upd_en.
  - stat_mispreds increments on each upd_en with upd_mispred.
  - Both wrap modulo 2^32; neither is cleared by flush_all.
- Reset (asynchronous, active-low):
  - All entries: valid = 0, target = 0, ctr = weakly-not-taken (MSB = 0, other bits 1).
  - Statistics counters = 0; GHR = 0.
  - Outputs while in reset: pred_taken = 0, pred_target = 0, pred_hist = 0.
  - Reset asserted mid-update discards the update.
- upd_en = 0: no state change, including with upd_mispred = 1.
- CTR_W = 1: the counter is a last-outcome bit. Weakly-taken = 1, weakly-not-taken = 0.

Optional Feature:
- Macro BPU_GHIST_EN.
- Defined (gshare indexing):
  - HIST_W-bit global history register (GHR).
  - Lookup index = idx(lk_pc) xor zero-extended GHR; pred_hist = GHR.
  - Update index = idx(upd_pc) xor zero-extended upd_hist.
  - On upd_en: GHR <= {upd_hist[HIST_W-2:0], upd_taken}. This repairs speculative divergence after a mispredict.
- Undefined:
  - No GHR register; index = idx(pc) only.
  - pred_hist is tied to 0 and upd_hist is ignored.

Decomposition:
- Shared package bpu_types_pkg holds:
  - btb_entry_t struct.
  - Counter init constants CTR_WEAK_T and CTR_WEAK_NT.
  - Helper function for index/tag extraction.
- One sub-module: sat_counter (parametrised CTR_W; inc/dec/hold; saturating).

Test Plan:
1. Reset, then lk_pc = 0x0000_0040 -> pred_taken = 0, pred_target = 0, pred_hist = 0.
2. upd_en with upd_pc = 0x40, taken, target 0x80 -> next cycle lk_pc = 0x40 gives pred_taken = 1, pred_target = 0x80. A second taken update saturates ctr at 2'b11; two not-taken updates then give pred_taken = 0.
3. Alias: allocate 0x40, then allocate 0x40 + 4*ENTRIES (0x80 for 16 entries) taken -> lookup of 0x40 misses (pred_taken = 0), lookup of 0x80 hits.
4. Same cycle: lk_pc = upd_pc = 0x40 on an allocating update -> pred_taken = 0 in that cycle, 1 in the next.
5. Five updates, two with upd_mispred = 1, then flush_all -> stat_lookups = 5, stat_mispreds = 2, and every lookup returns pred_taken = 0.
6. With BPU_GHIST_EN: updates with upd_taken 1,1,0,1 from GHR = 0 -> GHR = 4'b1101. The same PC then indexes different entries under different pred_hist values.
